round_pack_arbiter: RTL and testbench
=====================================

Name: round_pack_arbiter

Overview:
- Round-robin arbiter that shares one roundAndPackFloat64 instance among NUM_REQ requesters, such as the FP multiply and divide normalisation stages.
- Takes one operand set per grant and drives the unit's ap_start/ap_ready handshake.
- OR-accumulates the exception-flag pulses the unit produces.
- Returns a tagged result over a valid/ready response channel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT_CYC, 16, watchdog limit in cycles; used only with RPA_TIMEOUT_EN

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot grant pulse; operands accepted this cycle
req_sign  in  NUM_REQ  packed zSign per requester
req_exp  in  13*NUM_REQ  packed zExp
req_sig  in  64*NUM_REQ  packed zSig
req_flags  in  32*NUM_REQ  packed incoming exception flags
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  requester index of the result
resp_data  out  64  packed float64
resp_flags  out  32  accumulated flags
core_start  out  1  to unit ap_start
core_ready  in  1  from unit ap_ready
core_sign/core_exp/core_sig/core_flag_i  out  1/13/64/32  registered operands to unit
core_flag_o  in  32  unit float_exception_flag_o
core_flag_vld  in  1  unit float_exception_flag_o_ap_vld
core_return  in  64  unit ap_return
core_rst  out  1  active-high reset to unit

Behaviour:
- Reset values (asynchronous, ap_rst_n=0):
  - state=IDLE; all outputs 0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Operand, id and flag registers are 0.
- The FSM has three states: IDLE, RUN, RESP.
- IDLE:
  - Pick the first requester with req_valid set, searching from rr_ptr+1 and wrapping modulo NUM_REQ.
  - In the same cycle, pulse req_ready for that requester (combinational from req_valid and state).
  - Register its sign, exp, sig and flags into core_* and into flag_acc; store id; set rr_ptr to the granted index.
  - Next state is RUN.
  - With no req_valid: stay in IDLE and leave rr_ptr unchanged.
- RUN:
  - core_start is held at 1 for the whole state; core_* operands stay stable.
  - On every cycle with core_flag_vld=1: flag_acc <= flag_acc | core_flag_o. This is needed because the unit ORs onto core_flag_i each time, not onto its own previous output.
  - core_ready is sampled only while core_start=1. The unit's idle-time ap_done is therefore never observed.
  - On core_ready=1:
    - resp_data <= core_return.
    - resp_flags <= flag_acc | (core_flag_vld ? core_flag_o : 0).
    - Next state is RESP.
    - core_start drops the following cycle.
  - The unit needs 2–4 cycles. Total request-to-resp_valid latency is therefore 3–5 cycles.
- RESP:
  - resp_valid=1 with resp_id, resp_data and resp_flags held stable.
  - When resp_valid and resp_ready are both 1, go to IDLE. No new grant happens in that cycle, so a new grant occurs no earlier than the next cycle.
- Requester obligations: req_valid and operands stay stable until req_ready. req_ready is never asserted in RUN or RESP.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,…
- Reset mid-operation: every register returns to its reset value immediately, and core_start drops.
  - core_rst is not asserted by reset. The unit owns its own reset, tied to the inverted, synchronised ap_rst_n at the top level.
- core_rst is 0 at all times unless RPA_TIMEOUT_EN is defined.

Optional Feature:
- Macro: RPA_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on RUN entry and increments every RUN cycle.
  - If it reaches TIMEOUT_CYC without core_ready:
    - core_rst pulses high for 1 cycle.
    - resp_data <= 64'h7FF8000000000000.
    - resp_flags <= flag_acc | 32'h80000000.
    - FSM goes to RESP.
- When undefined: no counter exists, core_rst is tied to 0, and RUN waits for core_ready indefinitely.

Test Plan:
- Requester 0: sign=0, exp=13'h3FE, sig=64'h4000000000000000, flags=0 -> resp_id=0, resp_data=64'h3FF0000000000000, resp_flags=0, resp_valid within 5 cycles of req_ready.
- Requester 2: exp=13'h0800, sig=64'h4000000000000000, flags=32'h10 -> resp_data=64'h7FF0000000000000, resp_flags=32'h19.
- Requester 1, tiny path with both the underflow and inexact pulses: exp=13'h1FFF, sig=64'h0000000000000201 -> resp_flags has bits 0 and 2 set. This checks OR accumulation across both pulses.
- All four requesters valid for 8 transactions, resp_ready=1 -> grant order 0,1,2,3,0,1,2,3; each req_ready pulse is one cycle long.
- resp_ready held at 0 for 10 cycles with requester 3 valid -> resp_* stable, req_ready stays 0, then requester 3 is granted the cycle after the response handshake. Reset asserted during RUN -> all outputs return to 0 asynchronously.
- RPA_TIMEOUT_EN with a core_ready stub that never responds -> core_rst pulses at RUN cycle 16, resp_data=64'h7FF8000000000000, resp_flags bit31=1.

Source files
------------

// File: rtl/round_pack_arbiter.sv
// round_pack_arbiter: round-robin sharing of one roundAndPackFloat64 unit among NUM_REQ requesters.
// Define RPA_TIMEOUT_EN to add a RUN watchdog that pulses core_rst and returns a flagged NaN.
`timescale 1ns/1ps
module round_pack_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_sign,
    input  logic [13*NUM_REQ-1:0] req_exp,
    input  logic [64*NUM_REQ-1:0] req_sig,
    input  logic [32*NUM_REQ-1:0] req_flags,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [63:0]           resp_data,
    output logic [31:0]           resp_flags,
    output logic                  core_start,
    input  logic                  core_ready,
    output logic                  core_sign,
    output logic [12:0]           core_exp,
    output logic [63:0]           core_sig,
    output logic [31:0]           core_flag_i,
    input  logic [31:0]           core_flag_o,
    input  logic                  core_flag_vld,
    input  logic [63:0]           core_return,
    output logic                  core_rst
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    state_t state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, pick_id, idx;
    logic pick_vld, sign_q, sign_d, timeout;
    logic [12:0] exp_q, exp_d;
    logic [63:0] sig_q, sig_d, data_q, data_d;
    logic [31:0] flag_q, flag_d, acc_q, acc_d, rflags_q, rflags_d;
    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("round_pack_arbiter: illegal parameter combination");
    end
    // Scan farthest-first so the requester right after rr_q is the last, winning, hit.
    always_comb begin
        pick_vld = 1'b0;
        pick_id = '0;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_id = idx;
            end
        end
    end
`ifdef RPA_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign cnt_d = (state_q == RUN) ? cnt_q + 1'b1 : '0;
    assign timeout = state_q == RUN && !core_ready && cnt_q == CNT_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif
    assign core_rst = timeout;
    assign req_ready = (ap_rst_n && state_q == IDLE && pick_vld) ? NUM_REQ'(1) << pick_id : '0;
    assign core_start = state_q == RUN;
    assign resp_valid = state_q == RESP;
    assign resp_id = id_q;
    assign resp_data = data_q;
    assign resp_flags = rflags_q;
    assign core_sign = sign_q;
    assign core_exp = exp_q;
    assign core_sig = sig_q;
    assign core_flag_i = flag_q;
    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        id_d = id_q;
        sign_d = sign_q;
        exp_d = exp_q;
        sig_d = sig_q;
        flag_d = flag_q;
        acc_d = acc_q;
        data_d = data_q;
        rflags_d = rflags_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = RUN;
                    rr_d = pick_id;
                    id_d = pick_id;
                    sign_d = req_sign[pick_id];
                    exp_d = req_exp[pick_id*13 +: 13];
                    sig_d = req_sig[pick_id*64 +: 64];
                    flag_d = req_flags[pick_id*32 +: 32];
                    acc_d = req_flags[pick_id*32 +: 32];
                end
            end
            RUN: begin
                // The unit ORs each pulse onto core_flag_i, so earlier pulses live only here.
                acc_d = acc_q | (core_flag_vld ? core_flag_o : 32'h0);
                if (core_ready) begin
                    state_d = RESP;
                    data_d = core_return;
                    rflags_d = acc_d;
                end else if (timeout) begin
                    state_d = RESP;
                    data_d = 64'h7FF8_0000_0000_0000;
                    rflags_d = acc_d | 32'h8000_0000;
                end
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            rr_q <= ID_W'(NUM_REQ - 1);
            id_q <= '0;
            sign_q <= 1'b0;
            exp_q <= '0;
            sig_q <= '0;
            flag_q <= '0;
            acc_q <= '0;
            data_q <= '0;
            rflags_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            id_q <= id_d;
            sign_q <= sign_d;
            exp_q <= exp_d;
            sig_q <= sig_d;
            flag_q <= flag_d;
            acc_q <= acc_d;
            data_q <= data_d;
            rflags_q <= rflags_d;
        end
    end
endmodule

// File: tb/tb_round_pack_arbiter.sv
// tb_round_pack_arbiter: vector table, directed corner sequences and a random run against a
// transaction-level model; the rounding unit is a behavioural roundAndPackFloat64 stub.
`timescale 1ns/1ps
module tb_round_pack_arbiter;
    localparam int N = 4;
    logic ap_clk = 1'b0, ap_rst_n = 1'b1;
    logic [N-1:0] req_valid = '0, req_ready, req_sign = '0;
    logic [13*N-1:0] req_exp = '0;
    logic [64*N-1:0] req_sig = '0;
    logic [32*N-1:0] req_flags = '0;
    logic resp_valid, resp_ready = 1'b0, core_start, core_ready = 1'b0, core_sign, core_flag_vld = 1'b0, core_rst;
    logic [1:0] resp_id;
    logic [63:0] resp_data, core_sig, core_return = '0;
    logic [31:0] resp_flags, core_flag_i, core_flag_o = '0;
    logic [12:0] core_exp;
    int total = 0, bad = 0;
    bit hang = 1'b0;
    typedef struct {
        int id;
        logic s;
        logic [12:0] e;
        logic [63:0] sig;
        logic [31:0] fl;
        logic [63:0] xd;
        logic [31:0] xf;
    } vec_t;

    always #5 ap_clk = ~ap_clk;

    round_pack_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYC(16)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
        .req_exp(req_exp), .req_sig(req_sig), .req_flags(req_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_flags(resp_flags),
        .core_start(core_start), .core_ready(core_ready), .core_sign(core_sign),
        .core_exp(core_exp), .core_sig(core_sig), .core_flag_i(core_flag_i),
        .core_flag_o(core_flag_o), .core_flag_vld(core_flag_vld),
        .core_return(core_return), .core_rst(core_rst)
    );

    // Round-to-nearest-even float64 pack; flag bits: inexact=1, underflow=4, overflow=8.
    function automatic void rap(input logic s, input logic [12:0] e, input logic [63:0] sig,
                                output logic [63:0] r, output logic [31:0] f);
        int ze;
        logic [63:0] z, sum;
        logic [9:0] rb;
        bit tiny;
        ze = int'($signed(e));
        z = sig;
        f = 32'h0;
        sum = z + 64'h200;
        if (ze >= 2045 && (ze > 2045 || sum[63])) begin
            f = 32'h9;
            r = {s, 11'h7FF, 52'h0};
            return;
        end
        if (ze < 0) begin
            tiny = ze < -1 || !sum[63];
            if (-ze >= 64) z = {63'h0, z != 64'h0};
            else z = (z >> (-ze)) | {63'h0, (z << (64 + ze)) != 64'h0};
            ze = 0;
            if (tiny && z[9:0] != 10'h0) f |= 32'h4;
        end
        rb = z[9:0];
        if (rb != 10'h0) f |= 32'h1;
        z = (z + 64'h200) >> 10;
        if (rb == 10'h200) z[0] = 1'b0;
        if (z == 64'h0) ze = 0;
        r = {s, 63'h0} + (64'(ze) << 52) + z;
    endfunction

    // Unit stub: 2..4 cycle latency, one flag pulse per raised bit ending on the ready cycle,
    // random ap_done noise while not started.
    int k = 0, lat = 2, np = 0;
    logic [63:0] res = '0;
    logic [31:0] raised = '0;
    logic [31:0] pl [2];
    always @(negedge ap_clk) begin
        if (core_start) k++;
        else k = 0;
        if (k == 1) begin
            rap(core_sign, core_exp, core_sig, res, raised);
            lat = $urandom_range(2, 4);
            np = 0;
            if (raised[3]) begin pl[0] = 32'h8; pl[1] = 32'h1; np = 2; end
            else if (raised[2]) begin pl[0] = 32'h4; pl[1] = 32'h1; np = 2; end
            else if (raised[0]) begin pl[0] = 32'h1; np = 1; end
        end
        core_ready = core_start ? (!hang && k == lat) : ($urandom_range(0, 3) == 0);
        core_return = (core_start && core_ready) ? res : 64'h0;
        core_flag_vld = core_start && !hang && k > lat - np && k <= lat;
        core_flag_o = 32'h0;
        if (core_flag_vld) core_flag_o = core_flag_i | pl[k - lat + np - 1];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ctl"}, {req_ready, resp_valid, resp_id, core_start, core_rst, core_sign}, 64'h0);
        check({nm, "_data"}, resp_data, 64'h0);
        check({nm, "_flags"}, {resp_flags, core_flag_i}, 64'h0);
        check({nm, "_sig"}, core_sig, 64'h0);
        check({nm, "_exp"}, core_exp, 64'h0);
    endtask

    task automatic set_req(input int i, input logic s, input logic [12:0] e, input logic [63:0] g,
                           input logic [31:0] f);
        req_valid[i] = 1'b1;
        req_sign[i] = s;
        req_exp[i*13 +: 13] = e;
        req_sig[i*64 +: 64] = g;
        req_flags[i*32 +: 32] = f;
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        req_valid = '0;
        resp_ready = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int i, input string nm);
        int c = 0;
        while (!req_ready[i] && c < 20) begin
            @(negedge ap_clk);
            #1;
            c++;
        end
        check(nm, req_ready, 64'h1 << i);
    endtask

    task automatic wait_resp(output int c);
        c = 1;
        while (!resp_valid && c < 10) begin
            @(negedge ap_clk);
            #1;
            c++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        @(negedge ap_clk);
        req_valid = '0;
        set_req(v.id, v.s, v.e, v.sig, v.fl);
        #1;
        wait_grant(v.id, "vec_grant");
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        wait_resp(c);
        check("vec_latency", c >= 3 && c <= 5, 64'h1);
        check("vec_id", resp_id, 64'(v.id));
        check("vec_data", resp_data, v.xd);
        check("vec_flags", resp_flags, v.xf);
        resp_ready = 1'b1;
        @(negedge ap_clk);
        resp_ready = 1'b0;
        #1;
        check("vec_resp_clear", resp_valid, 64'h0);
    endtask

    task automatic rnd_op(input int i);
        logic [12:0] e;
        logic [63:0] g;
        g = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: begin e = 13'($urandom_range(1, 'h7FC)); g[63:62] = 2'b01; end
            1: e = 13'h7FD;
            2: e = 13'($urandom_range('h7FE, 'hFFF));
            3: begin e = 13'h1FFF - 13'($urandom_range(0, 70)); g = g >> $urandom_range(1, 63); end
            default: begin e = 13'h0; g = g >> $urandom_range(1, 63); end
        endcase
        set_req(i, 1'($urandom_range(0, 1)), e, g, $urandom & 32'h0000_01FF);
    endtask

    initial begin
        vec_t vt [5];
        int c, n, g, last, gcyc, xid;
        bit busy, seen;
        logic [63:0] xd;
        logic [31:0] xf;
        logic [N-1:0] drop;
        vt[0] = '{0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 32'h0, 64'h3FF0_0000_0000_0000, 32'h0};
        vt[1] = '{2, 1'b0, 13'h0800, 64'h4000_0000_0000_0000, 32'h10, 64'h7FF0_0000_0000_0000, 32'h19};
        vt[2] = '{1, 1'b0, 13'h1FFF, 64'h0000_0000_0000_0201, 32'h0, 64'h0, 32'h5};
        vt[3] = '{3, 1'b1, 13'h3FF, 64'h4000_0000_0000_0000, 32'h0, 64'hC000_0000_0000_0000, 32'h0};
        vt[4] = '{0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0200, 32'h100, 64'h3FF0_0000_0000_0000, 32'h101};
        #1 ap_rst_n = 1'b0;
        #2;
        check_zero("reset");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(vt[i]);
        // Fairness: all requesters held valid, consumer always ready.
        do_reset();
        @(negedge ap_clk);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 32'h0);
        resp_ready = 1'b1;
        #1;
        for (int t = 0; t < 8; t++) begin
            c = 0;
            while (req_ready == '0 && c < 12) begin
                @(negedge ap_clk);
                #1;
                c++;
            end
            check("rr_order", req_ready, 64'h1 << (t % N));
            @(negedge ap_clk);
            #1;
            check("rr_pulse", req_ready, 64'h0);
        end
        req_valid = '0;
        repeat (8) @(negedge ap_clk);
        resp_ready = 1'b0;
        // Backpressure: result held while requester 3 waits, then granted right after handshake.
        @(negedge ap_clk);
        set_req(1, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 32'h2);
        #1;
        wait_grant(1, "bp_grant1");
        @(negedge ap_clk);
        req_valid = '0;
        set_req(3, 1'b1, 13'h400, 64'h4000_0000_0000_0000, 32'h0);
        #1;
        wait_resp(c);
        check("bp_resp_seen", resp_valid, 64'h1);
        for (int i = 0; i < 10; i++) begin
            check("bp_data", resp_data, 64'h3FF0_0000_0000_0000);
            check("bp_meta", {resp_valid, resp_id, resp_flags, req_ready}, {1'b1, 2'd1, 32'h2, 4'b0000});
            @(negedge ap_clk);
            #1;
        end
        resp_ready = 1'b1;
        #1;
        check("bp_handshake_no_grant", req_ready, 64'h0);
        @(negedge ap_clk);
        resp_ready = 1'b0;
        #1;
        check("bp_grant3_next", req_ready, 64'h8);
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        wait_resp(c);
        check("bp_req3_data", resp_data, 64'hC010_0000_0000_0000);
        resp_ready = 1'b1;
        @(negedge ap_clk);
        resp_ready = 1'b0;
        // Asynchronous reset in the middle of RUN.
        set_req(2, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 32'h40);
        #1;
        wait_grant(2, "mid_grant");
        @(negedge ap_clk);
        req_valid = '0;
        #1;
        check("mid_running", {core_start, core_flag_i}, {1'b1, 32'h40});
        #2 ap_rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
`ifdef RPA_TIMEOUT_EN
        // Unit that never answers: watchdog fires on the 16th RUN cycle.
        do_reset();
        hang = 1'b1;
        set_req(0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 32'h3);
        #1;
        wait_grant(0, "to_grant");
        @(negedge ap_clk);
        req_valid = '0;
        n = 0;
        for (int t = 0; t < 40 && n < 16; t++) begin
            #1;
            if (core_start) begin
                n++;
                check("to_rst_level", core_rst, 64'(n == 16));
            end
            if (n < 16) @(negedge ap_clk);
        end
        check("to_run_cycles", n, 64'd16);
        @(negedge ap_clk);
        #1;
        check("to_rst_pulse_end", core_rst, 64'h0);
        check("to_resp", {resp_valid, resp_flags}, {1'b1, 32'h8000_0003});
        check("to_data", resp_data, 64'h7FF8_0000_0000_0000);
        resp_ready = 1'b1;
        @(negedge ap_clk);
        resp_ready = 1'b0;
        hang = 1'b0;
`endif
        // Random traffic against a transaction-level model.
        do_reset();
        last = N - 1;
        busy = 1'b0;
        seen = 1'b0;
        gcyc = 0;
        xid = 0;
        xd = '0;
        xf = '0;
        drop = '0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge ap_clk);
            req_valid &= ~drop;
            drop = '0;
            for (int i = 0; i < N; i++) if (!req_valid[i] && $urandom_range(0, 3) == 0) rnd_op(i);
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            if (!busy) begin
                g = -1;
                for (int j = 1; j <= N; j++) if (g < 0 && req_valid[(last + j) % N]) g = (last + j) % N;
                check("rnd_grant", req_ready, g < 0 ? 64'h0 : 64'h1 << g);
                check("rnd_idle_resp", resp_valid, 64'h0);
                if (g >= 0) begin
                    busy = 1'b1;
                    seen = 1'b0;
                    last = g;
                    xid = g;
                    gcyc = t;
                    drop[g] = 1'b1;
                    rap(req_sign[g], req_exp[g*13 +: 13], req_sig[g*64 +: 64], xd, xf);
                    xf |= req_flags[g*32 +: 32];
                end
            end else begin
                check("rnd_no_grant", req_ready, 64'h0);
                if (resp_valid) begin
                    if (!seen) check("rnd_latency", (t - gcyc) >= 3 && (t - gcyc) <= 5, 64'h1);
                    seen = 1'b1;
                    check("rnd_id", resp_id, 64'(xid));
                    check("rnd_data", resp_data, xd);
                    check("rnd_flags", resp_flags, xf);
                    if (resp_ready) busy = 1'b0;
                end else if (t - gcyc > 5) begin
                    check("rnd_resp_missing", resp_valid, 64'h1);
                    busy = 1'b0;
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
